varlat_bank_responder: RTL and testbench

Bank-side responder for the variable-latency in-order TCDM interconnect. It accepts req/gnt requests from one interconnect output port and drives a fixed-latency SRAM macro. Each response is returned on an rvalid/rready handshake in acceptance order. A credit counter and a response FIFO ensure that SRAM read data is never lost while the interconnect applies backpressure on rready.

---
 rtl/varlat_bank_responder.sv | 150 +++++++++++++++
 tb/tb_varlat_bank_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varlat_bank_responder.sv
// Bank-side responder: grants interconnect requests against a credit budget, drives a
// fixed-latency SRAM and returns in-order responses through a fall-through FIFO.
module varlat_bank_responder #(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned SramLatency  = 1,
  parameter int unsigned RspDepth     = 2,
  parameter bit          WriteRespOn  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    we_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrMemWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]    sram_wdata_o,
  output logic [BeWidth-1:0]      sram_be_o,
  input  logic [DataWidth-1:0]    sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(RspDepth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(RspDepth - 1);

  if (SramLatency < 1) begin : g_bad_latency
    $fatal(1, "varlat_bank_responder: SramLatency must be >= 1");
  end
  if (RspDepth < 1) begin : g_bad_depth
    $fatal(1, "varlat_bank_responder: RspDepth must be >= 1");
  end

  logic [CntW-1:0]      cnt_reg, cnt_next;
  logic                 accept, needs_rsp, push, push_is_wr, pop;
  logic [DataWidth-1:0] push_data;

  // Request side: grant depends only on the registered credit count.
  assign gnt_o        = !rst_i && (cnt_reg < CntMax);
  assign accept       = req_i && gnt_o;
  assign needs_rsp    = accept && (!we_i || WriteRespOn);
  assign sram_req_o   = accept;
  assign sram_we_o    = we_i;
  assign sram_addr_o  = add_i;
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  // Tracking pipe mirrors the SRAM latency; it never stalls since credits reserve FIFO room.
  logic [SramLatency-1:0] pipe_vld_reg, pipe_wr_reg;
  logic [SramLatency:0]   vld_chain, wr_chain;

  assign vld_chain[0] = needs_rsp;
  assign wr_chain[0]  = we_i;
  for (genvar gi = 0; gi < SramLatency; gi++) begin : g_pipe
    assign vld_chain[gi+1] = pipe_vld_reg[gi];
    assign wr_chain[gi+1]  = pipe_wr_reg[gi];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_reg <= '0;
      pipe_wr_reg  <= '0;
    end else begin
      pipe_vld_reg <= vld_chain[SramLatency-1:0];
      pipe_wr_reg  <= wr_chain[SramLatency-1:0];
    end
  end

  assign push       = vld_chain[SramLatency];
  assign push_is_wr = wr_chain[SramLatency];
  assign push_data  = push_is_wr ? '0 : sram_rdata_i;

  // Response FIFO with fall-through: an incoming entry is visible the cycle it arrives.
  logic [DataWidth-1:0] fifo_mem_reg [RspDepth];
  logic [PtrW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]      fifo_cnt_reg, fifo_cnt_next;
  logic                 fifo_empty, fifo_full, fifo_wr, fifo_rd;

  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == CntMax);

  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    if (!rst_i) begin
      rvalid_o = !fifo_empty || push;
      if (!fifo_empty) begin
        rdata_o = fifo_mem_reg[rd_ptr_reg];
      end else if (push) begin
        rdata_o = push_data;
      end
    end
  end

  assign pop     = rvalid_o && rready_i;
  assign fifo_rd = pop && !fifo_empty;
  assign fifo_wr = push && !(fifo_empty && pop);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({fifo_wr, fifo_rd})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({needs_rsp, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      fifo_mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      assert (!(push && fifo_full));
      cnt_reg      <= cnt_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (fifo_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (fifo_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

endmodule

// File: tb/tb_varlat_bank_responder.sv
// Directed bench for varlat_bank_responder: three configurations share one stimulus stream,
// each with its own behavioural SRAM, and each phase checks the configuration it targets.
module tb_varlat_bank_responder;

  logic        clk, rst, req, we, rready, load_mem;
  logic [11:0] add;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt_a, rvalid_a, sram_req_a, sram_we_a;
  logic [11:0] sram_addr_a;
  logic [31:0] rdata_a, sram_wdata_a, sram_rdata_a;
  logic [3:0]  sram_be_a;

  logic        gnt_b, rvalid_b, sram_req_b, sram_we_b;
  logic [11:0] sram_addr_b;
  logic [31:0] rdata_b, sram_wdata_b, sram_rdata_b;
  logic [3:0]  sram_be_b;

  logic        gnt_c, rvalid_c, sram_req_c, sram_we_c;
  logic [11:0] sram_addr_c;
  logic [31:0] rdata_c, sram_wdata_c, sram_rdata_c, rd_c_p0, rd_c_p1;
  logic [3:0]  sram_be_c;

  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  logic [31:0] mem_c [4096];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory contents; small addresses and 0x010 carry the directed values.
  function automatic logic [31:0] f(input logic [11:0] i);
    if (i < 12'd8) return {20'h0, i};
    if (i == 12'h010) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ {i, 4'h0, i, 4'h3};
  endfunction

  varlat_bank_responder #(.SramLatency(1), .RspDepth(2), .WriteRespOn(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_a), .rready_i(rready), .rdata_o(rdata_a),
    .sram_req_o(sram_req_a), .sram_we_o(sram_we_a), .sram_addr_o(sram_addr_a),
    .sram_wdata_o(sram_wdata_a), .sram_be_o(sram_be_a), .sram_rdata_i(sram_rdata_a));

  varlat_bank_responder #(.SramLatency(1), .RspDepth(2), .WriteRespOn(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_b), .rready_i(rready), .rdata_o(rdata_b),
    .sram_req_o(sram_req_b), .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b),
    .sram_wdata_o(sram_wdata_b), .sram_be_o(sram_be_b), .sram_rdata_i(sram_rdata_b));

  varlat_bank_responder #(.SramLatency(3), .RspDepth(4), .WriteRespOn(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_c), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_c), .rready_i(rready), .rdata_o(rdata_c),
    .sram_req_o(sram_req_c), .sram_we_o(sram_we_c), .sram_addr_o(sram_addr_c),
    .sram_wdata_o(sram_wdata_c), .sram_be_o(sram_be_c), .sram_rdata_i(sram_rdata_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macros: read-first, byte-enabled writes.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= f(12'(i));
    end else begin
      sram_rdata_a <= mem_a[sram_addr_a];
      if (sram_req_a && sram_we_a)
        for (int k = 0; k < 4; k++)
          if (sram_be_a[k]) mem_a[sram_addr_a][k*8 +: 8] <= sram_wdata_a[k*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem_b[i] <= f(12'(i));
    end else begin
      sram_rdata_b <= mem_b[sram_addr_b];
      if (sram_req_b && sram_we_b)
        for (int k = 0; k < 4; k++)
          if (sram_be_b[k]) mem_b[sram_addr_b][k*8 +: 8] <= sram_wdata_b[k*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem_c[i] <= f(12'(i));
    end else begin
      rd_c_p0      <= mem_c[sram_addr_c];
      rd_c_p1      <= rd_c_p0;
      sram_rdata_c <= rd_c_p1;
      if (sram_req_c && sram_we_c)
        for (int k = 0; k < 4; k++)
          if (sram_be_c[k]) mem_c[sram_addr_c][k*8 +: 8] <= sram_wdata_c[k*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [11:0] ra;

  initial begin
    rst = 1'b1; load_mem = 1'b1; req = 1'b1; add = '0; we = 1'b0;
    wdata = '0; be = 4'hF; rready = 1'b1;
    tick;
    load_mem = 1'b0;

    // Reset state, with req_i held high to show nothing leaks through.
    sample;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_sram_req", sram_req_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    req = 1'b0;
    tick;
    rst = 1'b0;
    sample;
    chk("post_rst_gnt", gnt_a, 1);
    chk("post_rst_rvalid", rvalid_a, 0);
    tick;

    // Single read of 0x010.
    req = 1'b1; add = 12'h010;
    sample;
    chk("single_gnt", gnt_a, 1);
    chk("single_sram_req", sram_req_a, 1);
    chk("single_rvalid_t0", rvalid_a, 0);
    tick;
    req = 1'b0;
    sample;
    chk("single_rvalid_t1", rvalid_a, 1);
    chk("single_rdata_t1", rdata_a, 32'hDEADBEEF);
    tick;
    sample;
    chk("single_rvalid_t2", rvalid_a, 0);
    tick;

    // Back-to-back reads of 0..7 with rready held high.
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; add = 12'(i);
      sample;
      chk("b2b_gnt", gnt_a, 1);
      if (i > 0) begin
        chk("b2b_rvalid", rvalid_a, 1);
        chk("b2b_rdata", rdata_a, 32'(i - 1));
      end
      tick;
    end
    req = 1'b0;
    sample;
    chk("b2b_rvalid_last", rvalid_a, 1);
    chk("b2b_rdata_last", rdata_a, 32'd7);
    tick;
    sample;
    chk("b2b_idle", rvalid_a, 0);
    tick;

    // Backpressure: two accepts fill the credits, then drain in order.
    rready = 1'b0; req = 1'b1; add = 12'd100;
    sample;
    chk("bp_gnt_c0", gnt_a, 1);
    tick;
    add = 12'd101;
    sample;
    chk("bp_gnt_c1", gnt_a, 1);
    chk("bp_rvalid_c1", rvalid_a, 1);
    chk("bp_rdata_c1", rdata_a, f(12'd100));
    tick;
    add = 12'd102;
    sample;
    chk("bp_gnt_c2", gnt_a, 0);
    chk("bp_sram_req_c2", sram_req_a, 0);
    chk("bp_rvalid_c2", rvalid_a, 1);
    chk("bp_rdata_c2", rdata_a, f(12'd100));
    tick;
    sample;
    chk("bp_gnt_c3", gnt_a, 0);
    chk("bp_rdata_c3", rdata_a, f(12'd100));
    tick;
    rready = 1'b1; req = 1'b0;
    sample;
    chk("bp_gnt_pop1", gnt_a, 0);
    chk("bp_rvalid_pop1", rvalid_a, 1);
    chk("bp_rdata_pop1", rdata_a, f(12'd100));
    tick;
    sample;
    chk("bp_gnt_after_pop", gnt_a, 1);
    chk("bp_rvalid_pop2", rvalid_a, 1);
    chk("bp_rdata_pop2", rdata_a, f(12'd101));
    tick;
    sample;
    chk("bp_drained", rvalid_a, 0);
    tick;

    // Partial-byte write with write responses enabled (dut_a) and disabled (dut_b).
    req = 1'b1; we = 1'b1; add = 12'h200; wdata = 32'hA5A5A5A5; be = 4'b0011;
    sample;
    chk("wr_sram_req", sram_req_a, 1);
    chk("wr_sram_we", sram_we_a, 1);
    chk("wr_sram_be", sram_be_a, 4'b0011);
    chk("wr_sram_wdata", sram_wdata_a, 32'hA5A5A5A5);
    tick;
    req = 1'b0; we = 1'b0; be = 4'hF;
    exp_w = f(12'h200);
    exp_w[15:0] = 16'hA5A5;
    sample;
    chk("wr_rvalid", rvalid_a, 1);
    chk("wr_rdata", rdata_a, 0);
    chk("wr_mem", mem_a[12'h200], exp_w);
    chk("wr_norsp_rvalid", rvalid_b, 0);
    tick;
    sample;
    chk("wr_rvalid_done", rvalid_a, 0);
    tick;

    for (int i = 0; i < 4; i++) begin
      req = 1'b1; we = 1'b1; add = 12'h300 + 12'(i); wdata = 32'(i);
      sample;
      chk("norsp_gnt", gnt_b, 1);
      chk("norsp_rvalid", rvalid_b, 0);
      tick;
    end
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample;
      chk("norsp_idle_rvalid", rvalid_b, 0);
      chk("norsp_idle_gnt", gnt_b, 1);
      tick;
    end

    // SramLatency=3, RspDepth=4: 20 random reads at full rate.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        req = 1'b1;
        ra = 12'd32 + 12'($urandom_range(0, 63));
        add = ra;
      end else begin
        req = 1'b0;
      end
      sample;
      if (c < 20) chk("lat3_gnt", gnt_c, 1);
      chk("lat3_rvalid", rvalid_c, (c >= 3 && c < 23) ? 32'd1 : 32'd0);
      if (rvalid_c && exp_q.size() > 0) chk("lat3_rdata", rdata_c, exp_q.pop_front());
      if (c < 20) exp_q.push_back(f(ra));
      tick;
    end
    chk("lat3_all_returned", exp_q.size(), 0);

    // Reset with two reads outstanding discards them.
    rready = 1'b0; req = 1'b1; add = 12'h040;
    sample;
    chk("mrst_gnt0", gnt_a, 1);
    tick;
    add = 12'h041;
    sample;
    chk("mrst_gnt1", gnt_a, 1);
    tick;
    req = 1'b0;
    sample;
    chk("mrst_pending_rvalid", rvalid_a, 1);
    chk("mrst_full_gnt", gnt_a, 0);
    tick;
    rst = 1'b1;
    sample;
    chk("mrst_in_rst_rvalid", rvalid_a, 0);
    chk("mrst_in_rst_gnt", gnt_a, 0);
    chk("mrst_in_rst_rdata", rdata_a, 0);
    tick;
    rst = 1'b0;
    sample;
    chk("mrst_release_gnt", gnt_a, 1);
    chk("mrst_release_rvalid", rvalid_a, 0);
    tick;
    sample;
    chk("mrst_stale_rvalid", rvalid_a, 0);
    tick;
    rready = 1'b1;
    sample;
    chk("mrst_stale_rvalid_rdy", rvalid_a, 0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
